// File: rtl/serv_axil_sram.sv
// AXI4-Lite scratchpad SRAM behind the SERV master port: byte-strobed word storage,
// independent single-outstanding read and write channels, SLVERR outside DEPTH words.
module serv_axil_sram #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DEPTH   = 512,
    parameter              MEMFILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_awaddr,
    input  logic          i_awvalid,
    output logic          o_awready,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic          i_wvalid,
    output logic          o_wready,
    output logic [1:0]    o_bresp,
    output logic          o_bvalid,
    input  logic          i_bready,
    input  logic [AW-1:0] i_araddr,
    input  logic          i_arvalid,
    output logic          o_arready,
    output logic [31:0]   o_rdata,
    output logic [1:0]    o_rresp,
    output logic          o_rlast,
    output logic          o_rvalid,
    input  logic          i_rready
);

    localparam int unsigned IW = AW - 2;
    localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] mem [DEPTH];

    logic          aw_hold_q, aw_hold_d;
    logic          w_hold_q,  w_hold_d;
    logic [IW-1:0] awidx_q,   awidx_d;
    logic [31:0]   wdata_q,   wdata_d;
    logic [3:0]    wstrb_q,   wstrb_d;
    logic          bvalid_q,  bvalid_d;
    logic [1:0]    bresp_q,   bresp_d;

    logic          rd_pend_q, rd_pend_d;
    logic [IW-1:0] aridx_q,   aridx_d;
    logic          rvalid_q,  rvalid_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic [1:0]    rresp_q,   rresp_d;

    logic aw_hs, w_hs, ar_hs, commit, aw_in_range, ar_in_range;

    // Byte-offset address bits carry no information for a word-wide slave.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_awaddr[1:0], i_araddr[1:0]};

    assign o_awready = !aw_hold_q && !bvalid_q;
    assign o_wready  = !w_hold_q && !bvalid_q;
    assign o_arready = !rd_pend_q && !rvalid_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_rvalid  = rvalid_q;
    assign o_rlast   = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = rresp_q;

    assign aw_hs       = i_awvalid && o_awready;
    assign w_hs        = i_wvalid && o_wready;
    assign ar_hs       = i_arvalid && o_arready;
    assign commit      = aw_hold_q && w_hold_q && !bvalid_q;
    assign aw_in_range = 32'(awidx_q) < DEPTH;
    assign ar_in_range = 32'(aridx_q) < DEPTH;

    // Write channel: latch AW and W independently, commit once both are held.
    always_comb begin
        aw_hold_d = aw_hold_q;
        w_hold_d  = w_hold_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_hold_d = 1'b1;
            awidx_d   = i_awaddr[AW-1:2];
        end
        if (w_hs) begin
            w_hold_d = 1'b1;
            wdata_d  = i_wdata;
            wstrb_d  = i_wstrb;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end
        if (bvalid_q && i_bready) begin
            bvalid_d  = 1'b0;
            aw_hold_d = 1'b0;
            w_hold_d  = 1'b0;
        end
    end

    // Read channel: one cycle from address capture to data; array read sees pre-edge contents.
    always_comb begin
        rd_pend_d = rd_pend_q;
        aridx_d   = aridx_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs) begin
            rd_pend_d = 1'b1;
            aridx_d   = i_araddr[AW-1:2];
        end
        if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            rvalid_d  = 1'b1;
            if (ar_in_range) begin
                rdata_d = mem[aridx_q[MW-1:0]];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = 32'h0;
                rresp_d = RESP_SLVERR;
            end
        end
        if (rvalid_q && i_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_hold_q <= 1'b0;
            w_hold_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rd_pend_q <= 1'b0;
            aridx_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_hold_q <= aw_hold_d;
            w_hold_q  <= w_hold_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rd_pend_q <= rd_pend_d;
            aridx_q   <= aridx_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Storage is never reset; only enabled byte lanes of in-range words change.
    always_ff @(posedge clk) begin
        if (commit && aw_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[awidx_q[MW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_serv_axil_sram.sv
// Directed bench for serv_axil_sram: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them at each response handshake.
module tb_serv_axil_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] i_awaddr;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wvalid;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready;
    logic [11:0] i_araddr;
    logic        i_arvalid;
    logic        o_arready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rlast;
    logic        o_rvalid;
    logic        i_rready;

    always #5 clk = ~clk;

    serv_axil_sram #(.AW(12), .DEPTH(512), .MEMFILE("")) dut (
        .clk(clk), .rst(rst),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
        .i_rready(i_rready)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [1:0]  mon_be;
    logic [33:0] mon_re;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compare at every B/R handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (o_bvalid === 1'b1 && i_bready) begin
                if (bq.size() == 0) timeout("b_unexpected");
                else begin
                    mon_be = bq.pop_front();
                    chk("bresp", 32'(o_bresp), 32'(mon_be));
                end
            end
            if (o_rvalid === 1'b1 && i_rready) begin
                if (rq.size() == 0) timeout("r_unexpected");
                else begin
                    mon_re = rq.pop_front();
                    chk("rdata", o_rdata, mon_re[33:2]);
                    chk("rresp", 32'(o_rresp), 32'(mon_re[1:0]));
                    chk("rlast", 32'(o_rlast), 32'(1));
                end
            end
        end
    end

    // W leads AW by w_lead cycles; checks one-edge commit latency after the later handshake.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp, input int w_lead);
        int cnt;
        logic aw_done, w_done, aw_acc, w_acc;
        bq.push_back(resp);
        i_awaddr = addr;
        i_wdata  = data;
        i_wstrb  = strb;
        i_wvalid = 1'b1;
        i_awvalid = (w_lead == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        cnt = 0;
        while (!(aw_done && w_done) && cnt < 30) begin
            aw_acc = i_awvalid && o_awready;
            w_acc  = i_wvalid && o_wready;
            tick();
            cnt++;
            if (aw_acc) begin aw_done = 1'b1; i_awvalid = 1'b0; end
            if (w_acc)  begin w_done  = 1'b1; i_wvalid  = 1'b0; end
            if (w_done && !aw_done && w_lead > 0) begin
                chk("w_only_wready", 32'(o_wready), 32'(0));
                chk("w_only_bvalid", 32'(o_bvalid), 32'(0));
            end
            if (!aw_done && !i_awvalid && cnt >= w_lead) i_awvalid = 1'b1;
        end
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
        if (!(aw_done && w_done)) timeout("aw_w_accept");
        cnt = 0;
        while (!o_bvalid && cnt < 10) begin tick(); cnt++; end
        chk("b_latency", cnt, 1);
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int cnt;
        logic acc;
        rq.push_back({data, resp});
        i_araddr  = addr;
        i_arvalid = 1'b1;
        acc = 1'b0;
        cnt = 0;
        while (!acc && cnt < 30) begin
            acc = o_arready;
            tick();
            cnt++;
        end
        i_arvalid = 1'b0;
        if (!acc) timeout("ar_accept");
        cnt = 0;
        while (!o_rvalid && cnt < 10) begin tick(); cnt++; end
        chk("r_latency", cnt, 1);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((bq.size() != 0 || rq.size() != 0) && cnt < 30) begin tick(); cnt++; end
        if (bq.size() != 0 || rq.size() != 0) timeout("drain");
        tick();
    endtask

    initial begin
        rst = 1'b1;
        i_awaddr = '0; i_awvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wvalid = 1'b0;
        i_bready = 1'b1; i_araddr = '0; i_arvalid = 1'b0; i_rready = 1'b1;

        // Reset asserted mid-cycle takes effect immediately.
        #12 rst = 1'b0;
        #1;
        chk("rst_awready", 32'(o_awready), 32'(1));
        chk("rst_wready",  32'(o_wready),  32'(1));
        chk("rst_arready", 32'(o_arready), 32'(1));
        chk("rst_bvalid",  32'(o_bvalid),  32'(0));
        chk("rst_rvalid",  32'(o_rvalid),  32'(0));
        chk("rst_rlast",   32'(o_rlast),   32'(0));
        chk("rst_bresp",   32'(o_bresp),   32'(0));
        chk("rst_rresp",   32'(o_rresp),   32'(0));
        chk("rst_rdata",   o_rdata,        32'h0);
        chk("rst_no_x", 32'($isunknown({o_awready, o_wready, o_bresp, o_bvalid, o_arready,
                                         o_rdata, o_rresp, o_rlast, o_rvalid})), 32'(0));
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Full-word write and readback.
        axi_write(12'h010, 32'h12345678, 4'hF, 2'b00, 0);
        axi_read(12'h010, 32'h12345678, 2'b00);
        drain();

        // W ahead of AW, partial strobes.
        axi_write(12'h010, 32'hAABBCCDD, 4'b0101, 2'b00, 3);
        axi_read(12'h010, 32'h12BB56DD, 2'b00);
        drain();

        // Zero strobes: OKAY, no change.
        axi_write(12'h010, 32'hFFFFFFFF, 4'h0, 2'b00, 0);
        axi_read(12'h010, 32'h12BB56DD, 2'b00);
        drain();

        // Out of range must not alias onto word 0.
        axi_write(12'h000, 32'hCAFEF00D, 4'hF, 2'b00, 0);
        axi_write(12'h800, 32'hDEADBEEF, 4'hF, 2'b10, 0);
        axi_read(12'h800, 32'h0, 2'b10);
        axi_read(12'h000, 32'hCAFEF00D, 2'b00);
        drain();

        // Backpressure on both response channels.
        i_bready = 1'b0;
        i_rready = 1'b0;
        axi_write(12'h030, 32'h55AA55AA, 4'hF, 2'b00, 0);
        axi_read(12'h010, 32'h12BB56DD, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bvalid",  32'(o_bvalid),  32'(1));
            chk("bp_bresp",   32'(o_bresp),   32'(0));
            chk("bp_rvalid",  32'(o_rvalid),  32'(1));
            chk("bp_rdata",   o_rdata,        32'h12BB56DD);
            chk("bp_awready", 32'(o_awready), 32'(0));
            chk("bp_wready",  32'(o_wready),  32'(0));
            chk("bp_arready", 32'(o_arready), 32'(0));
        end
        i_bready = 1'b1;
        i_rready = 1'b1;
        tick();
        chk("bp_bvalid_done", 32'(o_bvalid), 32'(0));
        chk("bp_rvalid_done", 32'(o_rvalid), 32'(0));
        tick();
        chk("bp_ready_back", 32'({o_awready, o_wready, o_arready}), 32'(3'b111));
        drain();

        // Commit and read of the same word on the same edge: read sees old data.
        axi_write(12'h020, 32'h1, 4'hF, 2'b00, 0);
        drain();
        chk("same_edge_ready", 32'({o_awready, o_wready, o_arready}), 32'(3'b111));
        bq.push_back(2'b00);
        rq.push_back({32'h1, 2'b00});
        i_awaddr = 12'h020; i_wdata = 32'h2; i_wstrb = 4'hF; i_araddr = 12'h020;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
        tick();
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        drain();
        axi_read(12'h020, 32'h2, 2'b00);
        drain();

        // Reset with a write response pending; memory survives reset.
        i_bready = 1'b0;
        axi_write(12'h040, 32'h00000077, 4'hF, 2'b00, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst_pend_bvalid",  32'(o_bvalid),  32'(0));
        chk("rst_pend_awready", 32'(o_awready), 32'(1));
        chk("rst_pend_wready",  32'(o_wready),  32'(1));
        bq.delete();
        tick();
        rst = 1'b1;
        i_bready = 1'b1;
        tick();
        axi_read(12'h020, 32'h2, 2'b00);
        axi_read(12'h040, 32'h00000077, 2'b00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
